// File: rtl/rnaxi_arb_pkg.sv
// Shared types and defaults for the ring-injection arbiter.
// Field widths here are the defaults for the matching rnaxi_arb parameters.
package rnaxi_arb_pkg;

  localparam int unsigned DefNumReq     = 4;
  localparam int unsigned TypeWidth     = 2;
  localparam int unsigned AttrWidth     = 3;
  localparam int unsigned SizeWidth     = 6;
  localparam int unsigned DataWidth     = 32;
  localparam int unsigned MaxBeats      = 64;
  localparam int unsigned LastBeatField = 1;

  localparam logic [TypeWidth-1:0] REQ_TYPE_WRITE = 2'd0;
  localparam logic [TypeWidth-1:0] REQ_TYPE_READ  = 2'd1;
  localparam logic [TypeWidth-1:0] REQ_TYPE_FLUSH = 2'd2;
  localparam logic [TypeWidth-1:0] REQ_TYPE_RES   = 2'd3;

  typedef enum logic [0:0] {
    StIdle,
    StPkt
  } arb_state_e;

  // Index width that stays legal for a single requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rnaxi_rr_pick.sv
// Round-robin priority pick: first set candidate at or after ptr_i, wrapping.
module rnaxi_rr_pick
  import rnaxi_arb_pkg::*;
#(
  parameter int unsigned NumReq = 4,
  localparam int unsigned IdxW = idx_width(NumReq)
) (
  input  logic [NumReq-1:0] cand_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              valid_o,
  output logic [IdxW-1:0]   idx_o
);

  int unsigned pos;

  always_comb begin
    valid_o = 1'b0;
    idx_o   = '0;
    pos     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      pos = 32'(ptr_i) + k;
      if (pos >= NumReq) begin
        pos = pos - NumReq;
      end
      if (!valid_o && cand_i[pos[IdxW-1:0]]) begin
        valid_o = 1'b1;
        idx_o   = pos[IdxW-1:0];
      end
    end
  end

endmodule

// File: rtl/rnaxi_arb.sv
// Packet-atomic round-robin arbiter injecting requester beats onto the ring.
// One owner at a time; ownership ends on a last-marked beat or a length overrun.
module rnaxi_arb
  import rnaxi_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ             = DefNumReq,
  parameter int unsigned REQ_TYPE_WIDTH      = TypeWidth,
  parameter int unsigned REQ_ATTR_WIDTH      = AttrWidth,
  parameter int unsigned REQ_SIZE_WIDTH      = SizeWidth,
  parameter int unsigned REQ_DATA_WIDTH      = DataWidth,
  parameter int unsigned REQ_MAX_BEATS       = MaxBeats,
  parameter int unsigned REQ_LAST_BEAT_FIELD = LastBeatField,
  localparam int unsigned IdxW = idx_width(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  r_req_valid,
  input  logic [NUM_REQ*REQ_TYPE_WIDTH-1:0]   r_req_type,
  input  logic [NUM_REQ*REQ_ATTR_WIDTH-1:0]   r_req_attr,
  input  logic [NUM_REQ*REQ_SIZE_WIDTH-1:0]   r_req_size,
  input  logic [NUM_REQ*REQ_DATA_WIDTH-1:0]   r_req_data,
  input  logic [NUM_REQ-1:0]                  r_req_intr,
  output logic [NUM_REQ-1:0]                  r_req_stall,
  input  logic [NUM_REQ-1:0]                  cfg_en,
  output logic                                d_req_valid,
  output logic [REQ_TYPE_WIDTH-1:0]           d_req_type,
  output logic [REQ_ATTR_WIDTH-1:0]           d_req_attr,
  output logic [REQ_SIZE_WIDTH-1:0]           d_req_size,
  output logic [REQ_DATA_WIDTH-1:0]           d_req_data,
  output logic                                d_req_intr,
  input  logic                                d_req_stall,
  output logic [IdxW-1:0]                     grant_id,
  output logic                                busy,
  output logic                                err_overrun
);

  localparam int unsigned CntW = REQ_SIZE_WIDTH + 1;

  arb_state_e                state_q, state_d;
  logic [IdxW-1:0]           rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]           grant_q, grant_d;
  logic [CntW-1:0]           beat_cnt_q, beat_cnt_d;
  logic                      err_q, err_d;
  logic                      dv_q, dv_d;
  logic [REQ_TYPE_WIDTH-1:0] type_q, type_d;
  logic [REQ_ATTR_WIDTH-1:0] attr_q, attr_d;
  logic [REQ_SIZE_WIDTH-1:0] size_q, size_d;
  logic [REQ_DATA_WIDTH-1:0] data_q, data_d;
  logic                      intr_q, intr_d;

  logic                      pick_valid;
  logic [IdxW-1:0]           pick_idx;
  logic                      g_valid, g_intr, g_last;
  logic [REQ_TYPE_WIDTH-1:0] g_type;
  logic [REQ_ATTR_WIDTH-1:0] g_attr, attr_eff;
  logic [REQ_SIZE_WIDTH-1:0] g_size;
  logic [REQ_DATA_WIDTH-1:0] g_data;
  logic                      accept, overrun, release_pkt;

  rnaxi_rr_pick #(
    .NumReq (NUM_REQ)
  ) u_pick (
    .cand_i  (r_req_valid & cfg_en),
    .ptr_i   (rr_ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  assign g_valid = r_req_valid[grant_q];
  assign g_intr  = r_req_intr[grant_q];
  assign g_type  = r_req_type[32'(grant_q)*REQ_TYPE_WIDTH +: REQ_TYPE_WIDTH];
  assign g_attr  = r_req_attr[32'(grant_q)*REQ_ATTR_WIDTH +: REQ_ATTR_WIDTH];
  assign g_size  = r_req_size[32'(grant_q)*REQ_SIZE_WIDTH +: REQ_SIZE_WIDTH];
  assign g_data  = r_req_data[32'(grant_q)*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
  assign g_last  = g_attr[REQ_LAST_BEAT_FIELD];

  assign accept      = (state_q == StPkt) && g_valid && !d_req_stall;
  assign overrun     = accept && !g_last && (beat_cnt_q == CntW'(REQ_MAX_BEATS));
  assign release_pkt = accept && (g_last || overrun);

  // An overrun beat is closed off as the packet's last beat.
  always_comb begin
    attr_eff = g_attr;
    if (overrun) begin
      attr_eff[REQ_LAST_BEAT_FIELD] = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    err_d      = overrun;
    dv_d       = dv_q;
    type_d     = type_q;
    attr_d     = attr_q;
    size_d     = size_q;
    data_d     = data_q;
    intr_d     = intr_q;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = StPkt;
        end
      end
      StPkt: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + CntW'(1);
        end
        if (release_pkt) begin
          state_d  = StIdle;
          rr_ptr_d = (grant_q == IdxW'(NUM_REQ - 1)) ? '0 : grant_q + IdxW'(1);
        end
      end
    endcase

    // Downstream stall freezes the whole output beat.
    if (!d_req_stall) begin
      dv_d   = accept;
      type_d = accept ? g_type : '0;
      attr_d = accept ? attr_eff : '0;
      size_d = accept ? g_size : '0;
      data_d = accept ? g_data : '0;
      intr_d = accept ? g_intr : 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      err_q      <= 1'b0;
      dv_q       <= 1'b0;
      type_q     <= '0;
      attr_q     <= '0;
      size_q     <= '0;
      data_q     <= '0;
      intr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      err_q      <= err_d;
      dv_q       <= dv_d;
      type_q     <= type_d;
      attr_q     <= attr_d;
      size_q     <= size_d;
      data_q     <= data_d;
      intr_q     <= intr_d;
    end
  end

  always_comb begin
    r_req_stall = '1;
    if (state_q == StPkt) begin
      r_req_stall[grant_q] = d_req_stall;
    end
  end

  assign d_req_valid = dv_q;
  assign d_req_type  = type_q;
  assign d_req_attr  = attr_q;
  assign d_req_size  = size_q;
  assign d_req_data  = data_q;
  assign d_req_intr  = intr_q;
  assign grant_id    = grant_q;
  assign busy        = (state_q == StPkt);
  assign err_overrun = err_q;

endmodule

// File: doc/rnaxi_arb.md
RNAXI_ARB -- requirements
Module: rnaxi_arb

Interface
REQ-001 Parameters (name, default, meaning), one per line: NUM_REQ 4 requester ports; REQ_TYPE_WIDTH 2; REQ_ATTR_WIDTH 3; REQ_SIZE_WIDTH 6; REQ_DATA_WIDTH 32; REQ_MAX_BEATS 64 max data beats per packet; REQ_LAST_BEAT_FIELD 1 attr bit marking last beat.
REQ-002 clk  in  1  clock; all state on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 r_req_valid  in  NUM_REQ  per-requester beat valid.
REQ-005 r_req_type/r_req_attr/r_req_size/r_req_data/r_req_intr  in  NUM_REQ x field width, flattened, port i at [i*W +: W]  per-requester beat fields.
REQ-006 r_req_stall  out  NUM_REQ  per-requester stall; combinational.
REQ-007 cfg_en  in  NUM_REQ  per-port arbitration enable.
REQ-008 d_req_valid/d_req_type/d_req_attr/d_req_size/d_req_data/d_req_intr  out  field widths  registered ring injection beat.
REQ-009 d_req_stall  in  1  downstream backpressure.
REQ-010 grant_id  out  clog2(NUM_REQ)  registered current owner; busy  out  1  high in S_PKT; err_overrun  out  1  one-cycle pulse.

Function
REQ-011 FSM states S_IDLE and S_PKT; the arbiter owns the ring packet-atomically: no interleaving of beats from different requesters.
REQ-012 S_IDLE: candidates = r_req_valid & cfg_en; if nonzero, grant_id <= first candidate at or after rr_ptr (round-robin, wrapping modulo NUM_REQ) and go to S_PKT; otherwise stay.
REQ-013 r_req_stall[i] = 1 for all i in S_IDLE and for every non-granted port; for the granted port in S_PKT, r_req_stall = d_req_stall.
REQ-014 Beat accepted when S_PKT && r_req_valid[grant_id] && !d_req_stall.
REQ-015 Output register: when d_req_stall=1 all d_req_* hold; when 0, d_req_valid <= accept and d_req_type/attr/size/data/intr <= granted fields if accept, else zero.
REQ-016 Latency: valid in S_IDLE cycle N -> grant at N+1 -> first beat on d_req_* at N+2 (no stall); one beat per cycle thereafter.
REQ-017 beat_cnt (REQ_SIZE_WIDTH+1 bits) clears on entry to S_PKT and increments per accepted beat.
REQ-018 Accepted beat with attr[REQ_LAST_BEAT_FIELD]=1 -> S_IDLE next cycle, rr_ptr <= (grant_id+1) mod NUM_REQ.
REQ-019 Overrun: accepted beat while beat_cnt == REQ_MAX_BEATS and last bit clear -> treated as last, d_req_attr last bit forced to 1, err_overrun pulses one cycle, release as REQ-018.
REQ-020 cfg_en changes affect only the next arbitration; clearing the owner's bit mid-packet does not truncate the packet.
REQ-021 Granted port deasserting valid mid-packet: ownership held, d_req_valid=0 bubbles, no timeout.
REQ-022 Single-beat packet (last set on header) occupies 2 cycles of arbiter time (S_IDLE + S_PKT).

Reset
REQ-023 On rst: state S_IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, busy=0, err_overrun=0, all d_req_* = 0.
REQ-024 rst mid-packet abandons the packet immediately; no partial beat is emitted after deassertion.
REQ-025 r_req_stall reads all-ones during and after reset until a grant.

Structure
REQ-026 Shared package holds REQ_TYPE_* encodings (WRITE 0, READ 1, FLUSH 2, RES 3), field widths, REQ_LAST_BEAT_FIELD, REQ_MAX_BEATS.
REQ-027 One sub-module: rnaxi_rr_pick (combinational round-robin priority pick from candidate vector and rr_ptr).

Verification
REQ-028 Ports 0 and 2 each present 3-beat writes, cfg_en=4'hF, rr_ptr=0 -> port 0 packet fully on d_req_* then port 2, no interleave, grant_id 0 then 2.
REQ-029 All 4 ports hold continuous single-beat reads -> grant order 0,1,2,3,0; each port serviced once per 4 packets.
REQ-030 d_req_stall=1 for 5 cycles mid-packet -> d_req_* frozen, granted r_req_stall=1, no beat lost or duplicated.
REQ-031 Port 1 sends 66 beats without last -> beat 65 emitted with last bit set, err_overrun pulse, arbiter returns to S_IDLE.
REQ-032 cfg_en=4'b1101 with port 1 valid alone -> never granted, r_req_stall[1]=1 throughout.
REQ-033 rst asserted on beat 2 of a 4-beat packet -> all outputs 0 next edge, S_IDLE, rr_ptr=0.
